// File: rtl/fpga_intc.sv
// rtl/fpga_intc.sv - 68040 board interrupt controller with strobe/ack register bus
// Define FPGA_INTC_EDGE_EN for edge-triggered sticky sources; default build is level-sensitive.
module fpga_intc #(
  parameter int NSRC = 4,
  parameter int WAIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fpga_stb,
  input  logic            fpga_we,
  input  logic            fpga_iack,
  input  logic [3:0]      fpga_addr,
  input  logic [7:0]      fpga_data,
  output logic            fpga_ack,
  output logic [31:0]     fpga_odata,
  input  logic [NSRC-1:0] irq,
  output logic [2:0]      out_ipl
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  localparam logic [3:0] WAIT_LAST = 4'((WAIT == 0) ? 0 : WAIT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      wait_cnt;
  logic            cap_we;
  logic            cap_iack;
  logic [3:0]      cap_addr;
  logic [7:0]      cap_data;

  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [2:0]      swint;
  logic [7:0]      vbase;
  logic [2:0]      level [NSRC];

  logic            wr_commit;
  logic            iack_commit;
  logic            hw_hit;
  logic [2:0]      hw_idx;
  logic            sw_hit;
  logic [7:0]      vector;
  logic [7:0]      rdata;
  logic [2:0]      active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fpga_stb) state_nxt = (WAIT == 0) ? S_ACK : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_HOLD;
      S_HOLD:  if (!fpga_stb) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fpga_ack   = (state == S_ACK);
    fpga_odata = fpga_ack ? {24'd0, rdata} : 32'd0;
  end

  // Transaction fields are frozen at capture so the master may change them after strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
      cap_we   <= 1'b0;
      cap_iack <= 1'b0;
      cap_addr <= 4'd0;
      cap_data <= 8'd0;
    end else if (state == S_IDLE && fpga_stb) begin
      wait_cnt <= 4'd0;
      cap_we   <= fpga_we;
      cap_iack <= fpga_iack;
      cap_addr <= fpga_addr;
      cap_data <= fpga_data;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign wr_commit   = fpga_ack && cap_we && !cap_iack;
  assign iack_commit = fpga_ack && cap_iack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  // Descending scan leaves the lowest matching index as the winner.
  always_comb begin
    hw_hit = 1'b0;
    hw_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i] && enable[i] && level[i] == cap_addr[2:0]) begin
        hw_hit = 1'b1;
        hw_idx = 3'(i);
      end
    end
    sw_hit = !hw_hit && (swint == cap_addr[2:0]) && (cap_addr[2:0] != 3'd0);
    if (hw_hit) begin
      vector = vbase + {5'd0, hw_idx};
    end else if (sw_hit) begin
      vector = vbase + 8'd8;
    end else begin
      vector = 8'h18;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (cap_iack) begin
      rdata = vector;
    end else if (!cap_addr[3]) begin
      case (cap_addr[2:0])
        3'd0:    rdata[NSRC-1:0] = pending;
        3'd1:    rdata[NSRC-1:0] = enable;
        3'd4:    rdata = {5'd0, swint};
        3'd5:    rdata = vbase;
        default: rdata = 8'h00;
      endcase
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (cap_addr[2:0] == 3'(i)) rdata = {5'd0, level[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable <= '0;
      swint  <= 3'd0;
      vbase  <= 8'h40;
      for (int i = 0; i < NSRC; i++) level[i] <= 3'd0;
    end else if (wr_commit) begin
      if (cap_addr == 4'h1) enable <= cap_data[NSRC-1:0];
      if (cap_addr == 4'h4) swint <= cap_data[2:0];
      if (cap_addr == 4'h5) vbase <= cap_data;
      for (int i = 0; i < NSRC; i++) begin
        if (cap_addr == 4'(8 + i)) level[i] <= cap_data[2:0];
      end
    end else if (iack_commit && sw_hit) begin
      swint <= 3'd0;
    end
  end

`ifdef FPGA_INTC_EDGE_EN
  logic [NSRC-1:0] sync_prev;
  logic [NSRC-1:0] pend_clr;

  always_comb begin
    pend_clr = '0;
    if (wr_commit && cap_addr == 4'h0) pend_clr = cap_data[NSRC-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (iack_commit && hw_hit && hw_idx == 3'(i)) pend_clr[i] = 1'b1;
    end
  end

  // A fresh edge wins over a clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_prev <= '0;
      pending   <= '0;
    end else begin
      sync_prev <= sync2;
      pending   <= (pending & ~pend_clr) | (sync2 & ~sync_prev);
    end
  end
`else
  assign pending = sync2;
`endif

  always_comb begin
    active = swint;
    for (int i = 0; i < NSRC; i++) begin
      if (pending[i] && enable[i] && level[i] > active) active = level[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_ipl <= 3'b111;
    end else begin
      out_ipl <= ~active;
    end
  end

endmodule

// File: tb/tb_fpga_intc.sv
// tb/tb_fpga_intc.sv - self-checking bench for fpga_intc against a cycle-level behavioural model
module tb_fpga_intc;

  localparam int NSRC = 4;
  localparam int WAIT = 3;
`ifdef FPGA_INTC_EDGE_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        fpga_stb;
  logic        fpga_we;
  logic        fpga_iack;
  logic [3:0]  fpga_addr;
  logic [7:0]  fpga_data;
  logic        fpga_ack;
  logic [31:0] fpga_odata;
  logic [3:0]  irq;
  logic [2:0]  out_ipl;

  int vectors = 0;
  int miscompares = 0;

  fpga_intc #(.NSRC(NSRC), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .fpga_stb(fpga_stb), .fpga_we(fpga_we),
    .fpga_iack(fpga_iack), .fpga_addr(fpga_addr), .fpga_data(fpga_data),
    .fpga_ack(fpga_ack), .fpga_odata(fpga_odata), .irq(irq), .out_ipl(out_ipl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model state: register contents as seen in the current cycle.
  int         cyc = 0;
  bit         started = 0;
  logic [3:0] s0, s1, s2;
  logic [3:0] m_pend, m_en;
  logic [2:0] m_sw, m_ipl;
  logic [7:0] m_vb;
  logic [2:0] m_lv [NSRC];
  bit         m_busy = 0;
  int         ack_cyc = 0;
  logic       c_we, c_iack;
  logic [3:0] c_addr;
  logic [7:0] c_data;

  function automatic int m_active();
    int a = int'(m_sw);
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_en[i] && int'(m_lv[i]) > a) a = int'(m_lv[i]);
    return a;
  endfunction

  // Returns source index, 8 for the software interrupt, -1 for spurious.
  function automatic int m_iack_pick(int l);
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_en[i] && int'(m_lv[i]) == l) return i;
    if (l != 0 && int'(m_sw) == l) return 8;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(logic ia, logic [3:0] a);
    int p;
    int idx;
    if (ia) begin
      p = m_iack_pick(int'(a[2:0]));
      if (p < 0) return 32'h18;
      return 32'((int'(m_vb) + p) % 256);
    end
    idx = int'(a) - 8;
    case (a)
      4'h0: return {28'd0, m_pend};
      4'h1: return {28'd0, m_en};
      4'h4: return {29'd0, m_sw};
      4'h5: return {24'd0, m_vb};
      default: begin
        if (idx >= 0 && idx < NSRC) return {29'd0, m_lv[idx]};
        return 32'd0;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    int c;
    int p;
    logic [3:0] clr;
    c = cyc;
    cyc = cyc + 1;
    started = 1;
    if (!rst) begin
      m_ipl = 3'b111; m_pend = 0; m_en = 0; m_sw = 0; m_vb = 8'h40;
      for (int i = 0; i < NSRC; i++) m_lv[i] = 0;
      m_busy = 0; s0 = 0; s1 = 0; s2 = 0;
    end else begin
      m_ipl = ~3'(m_active());
      clr = 4'd0;
      if (m_busy && c == ack_cyc) begin
        if (c_iack) begin
          p = m_iack_pick(int'(c_addr[2:0]));
          if (p == 8) m_sw = 0;
          else if (p >= 0) clr[p] = 1'b1;
        end else if (c_we) begin
          case (c_addr)
            4'h0: clr = c_data[3:0];
            4'h1: m_en = c_data[3:0];
            4'h4: m_sw = c_data[2:0];
            4'h5: m_vb = c_data;
            default: if (c_addr >= 4'h8 && int'(c_addr) < 8 + NSRC) m_lv[int'(c_addr) - 8] = c_data[2:0];
          endcase
        end
      end
`ifdef FPGA_INTC_EDGE_EN
      m_pend = (m_pend & ~clr) | (s1 & ~s2);
`else
      m_pend = s0;
`endif
      if (!m_busy && fpga_stb) begin
        c_we = fpga_we; c_iack = fpga_iack; c_addr = fpga_addr; c_data = fpga_data;
        ack_cyc = c + WAIT + 1;
        m_busy = 1;
      end else if (m_busy && c > ack_cyc && !fpga_stb) begin
        m_busy = 0;
      end
      s2 = s1; s1 = s0; s0 = irq;
    end
  end

  always @(negedge clk) begin
    logic exp_ack;
    if (started) begin
      exp_ack = m_busy && (cyc == ack_cyc);
      chk("ack", {31'd0, fpga_ack}, {31'd0, exp_ack});
      chk("odata", fpga_odata, exp_ack ? m_read(c_iack, c_addr) : 32'd0);
      chk("ipl", {29'd0, out_ipl}, {29'd0, m_ipl});
    end
  end

  task automatic bus(input logic we, input logic ia, input logic [3:0] a,
                     input logic [7:0] d, input int hold, output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    fpga_stb = 1; fpga_we = we; fpga_iack = ia; fpga_addr = a; fpga_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (!fpga_ack && n < 20);
    chk("ack_latency", 32'(n), 32'(WAIT + 1));
    rd = fpga_odata;
    repeat (hold) @(negedge clk);
    fpga_stb = 0; fpga_we = 0; fpga_iack = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    rst = 0; fpga_stb = 0; fpga_we = 0; fpga_iack = 0; fpga_addr = 0; fpga_data = 0; irq = 0;
    repeat (4) @(negedge clk);
    chk("rst_ipl", 32'(out_ipl), 32'h7);
    chk("rst_ack", 32'(fpga_ack), 32'h0);
    chk("rst_odata", fpga_odata, 32'h0);
    rst = 1;

    bus(0, 0, 4'h5, 8'h00, 3, rd); chk("rd_vbase_rst", rd, 32'h40);
    bus(0, 0, 4'h0, 8'h00, 0, rd); chk("rd_pend_rst", rd, 32'h00);

    bus(1, 0, 4'hA, 8'h05, 0, rd);
    bus(1, 0, 4'h1, 8'h04, 0, rd);
    irq[2] = 1;
    repeat (IRQ_LAT) @(negedge clk);
    chk("ipl_before_src2", 32'(out_ipl), 32'h7);
    @(negedge clk);
    chk("ipl_src2_lvl5", 32'(out_ipl), 32'h2);
`ifdef FPGA_INTC_EDGE_EN
    irq[2] = 0;
`endif
    bus(0, 0, 4'h0, 8'h00, 0, rd); chk("rd_pend_src2", rd, 32'h04);

    irq[2] = 0;
    bus(1, 0, 4'h0, 8'h04, 0, rd);
    repeat (5) @(negedge clk);
    bus(0, 0, 4'h0, 8'h00, 0, rd); chk("rd_pend_cleared", rd, 32'h00);

    irq[1] = 1; irq[3] = 1;
    bus(1, 0, 4'h9, 8'h03, 0, rd);
    bus(1, 0, 4'hB, 8'hFB, 0, rd);
    bus(1, 0, 4'h1, 8'hFA, 0, rd);
`ifdef FPGA_INTC_EDGE_EN
    bus(0, 1, 4'h3, 8'h00, 0, rd); chk("iack3_first", rd, 32'h41);
    bus(0, 0, 4'h0, 8'h00, 0, rd); chk("pend_after_iack", rd, 32'h08);
    bus(0, 1, 4'h3, 8'h00, 0, rd); chk("iack3_second", rd, 32'h43);
    bus(0, 1, 4'h3, 8'h00, 0, rd); chk("iack3_spurious", rd, 32'h18);
`else
    bus(0, 1, 4'h3, 8'h00, 0, rd); chk("iack3_first", rd, 32'h41);
    bus(0, 0, 4'h0, 8'h00, 0, rd); chk("pend_after_iack", rd, 32'h0A);
    bus(0, 1, 4'h3, 8'h00, 0, rd); chk("iack3_second", rd, 32'h41);
    bus(0, 1, 4'hB, 8'h00, 0, rd); chk("iack3_third", rd, 32'h41);
`endif
    irq[1] = 0; irq[3] = 0;
    bus(1, 0, 4'h0, 8'h0A, 0, rd);

    bus(1, 0, 4'h8, 8'h02, 0, rd);
    bus(1, 0, 4'h1, 8'h01, 0, rd);
    irq[0] = 1;
    repeat (5) @(negedge clk);
    chk("ipl_src0_lvl2", 32'(out_ipl), 32'h5);
    bus(1, 0, 4'h4, 8'hFE, 0, rd);
    @(negedge clk);
    chk("ipl_swint6", 32'(out_ipl), 32'h1);
    bus(0, 1, 4'h6, 8'h00, 0, rd); chk("iack6_swint", rd, 32'h48);
    bus(0, 0, 4'h4, 8'h00, 0, rd); chk("rd_swint_cleared", rd, 32'h00);
    chk("ipl_after_swint", 32'(out_ipl), 32'h5);

    bus(1, 0, 4'h5, 8'h60, 0, rd);
    bus(0, 0, 4'h5, 8'h00, 0, rd); chk("rd_vbase_new", rd, 32'h60);
    bus(0, 1, 4'h2, 8'h00, 0, rd); chk("iack2_src0", rd, 32'h60);
    bus(0, 0, 4'h8, 8'h00, 0, rd); chk("rd_level0", rd, 32'h02);
    bus(0, 0, 4'h2, 8'h00, 0, rd); chk("rd_unmapped", rd, 32'h00);
    bus(0, 0, 4'hC, 8'h00, 0, rd); chk("rd_level_oob", rd, 32'h00);
    bus(1, 0, 4'h3, 8'hFF, 0, rd);
    bus(1, 1, 4'h1, 8'h00, 0, rd);
    bus(0, 0, 4'h1, 8'h00, 0, rd); chk("rd_enable_kept", rd, 32'h01);

    // Rising irq[2] lands on the same edge that commits the W1C of bit 2.
    fork
      bus(1, 0, 4'h0, 8'h04, 0, rd);
      begin
        repeat (3) @(negedge clk);
        irq[2] = 1;
      end
    join
    repeat (2) @(negedge clk);
    bus(0, 0, 4'h0, 8'h00, 0, rd);
`ifdef FPGA_INTC_EDGE_EN
    chk("pend_set_beats_clr", rd, 32'h04);
`else
    chk("pend_set_beats_clr", rd, 32'h05);
`endif

    irq = 0;
    repeat (6) @(negedge clk);
    fpga_stb = 1; fpga_we = 1; fpga_iack = 0; fpga_addr = 4'h1; fpga_data = 8'h0F;
    repeat (2) @(negedge clk);
    rst = 0; fpga_stb = 0; fpga_we = 0;
    repeat (4) begin
      @(negedge clk);
      chk("no_ack_in_reset", 32'(fpga_ack), 32'h0);
    end
    rst = 1;
    bus(0, 0, 4'h1, 8'h00, 0, rd); chk("rd_enable_after_rst", rd, 32'h00);
    bus(0, 0, 4'h5, 8'h00, 0, rd); chk("rd_vbase_after_rst", rd, 32'h40);
    chk("ipl_after_rst", 32'(out_ipl), 32'h7);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
